spi_minion_phy: RTL and testbench

//  SPI minion physical stage (mode 0, MSB first) between the SPI pins and the minion adapter.

---
 rtl/spi_minion_phy.sv | 167 ++++++++++++++++
 tb/tb_spi_minion_phy.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_minion_phy.sv
// ============================================================================
//  Module      : spi_minion_phy
//  Description : SPI minion physical stage (mode 0, MSB first). Synchronises
//                the SPI pins, pulls a response word on cs fall, shifts it
//                out on miso and pushes the captured mosi frame on cs rise.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_minion_phy #(
    parameter int NBITS       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cs,
    input  logic             i_sclk,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_pull_en,
    input  logic             i_pull_msg_val,
    input  logic             i_pull_msg_spc,
    input  logic [NBITS-3:0] i_pull_msg_data,
    output logic             o_push_en,
    output logic             o_push_msg_val_wrt,
    output logic             o_push_msg_val_rd,
    output logic [NBITS-3:0] o_push_msg_data,
    output logic             o_frame_err
);

    localparam int             c_CW       = $clog2(NBITS + 2);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(NBITS);
    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(NBITS + 1);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_prev;
    logic                   r_sclk_prev;

    logic                   w_cs_s;
    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sck_rise;
    logic                   w_sck_fall;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;

    logic [NBITS-1:0]       r_shreg;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_miso;
    logic                   r_push_wrt;
    logic                   r_push_rd;
    logic [NBITS-3:0]       r_push_data;

    logic                   w_pull_en;
    logic                   w_push_en;
    logic                   w_frame_err;

    // cs synchroniser resets high so a cs held low across reset release
    // still produces a cs_fall and starts a clean frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_prev   <= w_cs_s;
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_prev & ~w_cs_s;
    assign w_cs_rise  = ~r_cs_prev & w_cs_s;
    assign w_sck_rise = ~r_sclk_prev & w_sclk_s;
    assign w_sck_fall = r_sclk_prev & ~w_sclk_s;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_cs_fall) w_state_nxt = c_ACTIVE;
            c_ACTIVE: if (w_cs_rise) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_pull_en   = 1'b0;
        w_push_en   = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            c_IDLE: w_pull_en = w_cs_fall;
            c_ACTIVE: begin
                if (w_cs_rise) begin
                    w_push_en   = (r_cnt == c_CNT_FULL);
                    w_frame_err = (r_cnt != c_CNT_FULL);
                end
            end
            default: ;
        endcase
    end

    // cs events take priority; sclk events are only honoured while ACTIVE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_miso      <= 1'b0;
            r_push_wrt  <= 1'b0;
            r_push_rd   <= 1'b0;
            r_push_data <= '0;
        end else if (w_pull_en) begin
            r_shreg <= {i_pull_msg_val, i_pull_msg_spc, i_pull_msg_data};
            r_miso  <= i_pull_msg_val;
            r_cnt   <= '0;
        end else if (r_state == c_IDLE) begin
            r_miso <= 1'b0;
        end else if (w_cs_rise) begin
            r_miso <= 1'b0;
            if (w_push_en) begin
                r_push_wrt  <= r_shreg[NBITS-1];
                r_push_rd   <= r_shreg[NBITS-2];
                r_push_data <= r_shreg[NBITS-3:0];
            end
        end else if (w_sck_rise) begin
            r_shreg <= {r_shreg[NBITS-2:0], w_mosi_s};
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_sck_fall) begin
            r_miso <= r_shreg[NBITS-1];
        end
    end

    assign o_miso             = r_miso;
    assign o_pull_en          = w_pull_en;
    assign o_push_en          = w_push_en;
    assign o_frame_err        = w_frame_err;
    assign o_push_msg_val_wrt = r_push_wrt;
    assign o_push_msg_val_rd  = r_push_rd;
    assign o_push_msg_data    = r_push_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_minion_phy.sv
// ============================================================================
//  Module      : tb_spi_minion_phy
//  Description : Self-checking bench for spi_minion_phy (nbits=8, 2 sync stages).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_minion_phy;

    localparam int NBITS = 8;
    localparam int HALF  = 6;

    logic             clk;
    logic             rst;
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             pull_en;
    logic             pull_val;
    logic             pull_spc;
    logic [NBITS-3:0] pull_data;
    logic             push_en;
    logic             push_wrt;
    logic             push_rd;
    logic [NBITS-3:0] push_data;
    logic             frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pull   = 0;
    int n_push   = 0;
    int n_ferr   = 0;

    logic [NBITS-1:0] model_push;

    spi_minion_phy #(.NBITS(NBITS), .SYNC_STAGES(2)) u_dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_cs               (cs),
        .i_sclk             (sclk),
        .i_mosi             (mosi),
        .o_miso             (miso),
        .o_pull_en          (pull_en),
        .i_pull_msg_val     (pull_val),
        .i_pull_msg_spc     (pull_spc),
        .i_pull_msg_data    (pull_data),
        .o_push_en          (push_en),
        .o_push_msg_val_wrt (push_wrt),
        .o_push_msg_val_rd  (push_rd),
        .o_push_msg_data    (push_data),
        .o_frame_err        (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pull_en)   n_pull++;
        if (push_en)   n_push++;
        if (frame_err) n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Host-side frame: pull word presented on cs fall, mosi shifted MSB first,
    // miso sampled just before each sclk rise as a mode-0 host would.
    task automatic run_frame(input int pulses, input logic [NBITS-1:0] pull_w,
                             input logic [NBITS-1:0] mosi_w, input string tag);
        int p0, u0, f0;
        logic good;
        p0 = n_pull; u0 = n_push; f0 = n_ferr;
        {pull_val, pull_spc, pull_data} = pull_w;
        cs = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < pulses; i++) begin
            mosi = (i < NBITS) ? mosi_w[NBITS-1-i] : 1'($urandom_range(0, 1));
            wait_clks(HALF);
            if (i < NBITS) chk($sformatf("%s_miso%0d", tag, i), 32'(miso), 32'(pull_w[NBITS-1-i]));
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        wait_clks(HALF);
        cs = 1'b1;
        wait_clks(8);
        good = (pulses == NBITS);
        if (good) model_push = mosi_w;
        chk({tag, "_pull"}, 32'(n_pull - p0), 32'd1);
        chk({tag, "_push"}, 32'(n_push - u0), good ? 32'd1 : 32'd0);
        chk({tag, "_ferr"}, 32'(n_ferr - f0), good ? 32'd0 : 32'd1);
        chk({tag, "_pmsg"}, 32'({push_wrt, push_rd, push_data}), 32'(model_push));
        chk({tag, "_miso_idle"}, 32'(miso), 32'd0);
    endtask

    initial begin
        int u0, f0, p0, pulses;
        logic [NBITS-1:0] pw, mw;

        // 1: reset held with pins toggling
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        pull_val = 1'b0; pull_spc = 1'b0; pull_data = '0;
        model_push = '0;
        for (int i = 0; i < 10; i++) begin
            cs = 1'($urandom_range(0, 1)); sclk = ~sclk; mosi = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_outs", 32'({miso, pull_en, push_en, push_wrt, push_rd, push_data, frame_err}), 32'd0);
            #1;
        end
        cs = 1'b1; sclk = 1'b0;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(6);
        chk("rst_strobes", 32'(n_pull + n_push + n_ferr), 32'd0);

        // 2: good frame
        run_frame(NBITS, {1'b1, 1'b1, 6'h2A}, 8'h95, "t2");
        chk("t2_fields", 32'({push_wrt, push_rd, push_data}), {24'd0, 1'b1, 1'b0, 6'h15});

        // 3/4: short and overflow frames
        run_frame(5, 8'h5C, 8'h3B, "t3");
        run_frame(9, 8'hA7, 8'hE1, "t4");

        // 5: sclk/mosi activity with cs high
        p0 = n_pull; u0 = n_push; f0 = n_ferr;
        for (int i = 0; i < 6; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = 1'b1; wait_clks(HALF);
            chk("t5_miso", 32'(miso), 32'd0);
            sclk = 1'b0; wait_clks(HALF);
        end
        wait_clks(6);
        chk("t5_strobes", 32'((n_pull - p0) + (n_push - u0) + (n_ferr - f0)), 32'd0);

        // 6: reset mid-frame, then a clean frame
        {pull_val, pull_spc, pull_data} = 8'hFF;
        cs = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1; wait_clks(HALF);
            sclk = 1'b1; wait_clks(HALF);
            sclk = 1'b0;
        end
        u0 = n_push; f0 = n_ferr;
        rst = 1'b1;
        wait_clks(3);
        cs = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        model_push = '0;
        wait_clks(8);
        chk("t6_abort", 32'((n_push - u0) + (n_ferr - f0)), 32'd0);
        chk("t6_rst_pmsg", 32'({push_wrt, push_rd, push_data}), 32'd0);
        run_frame(NBITS, {1'b1, 1'b1, 6'h2A}, 8'h95, "t6");

        // randomized frames: half full-length, half arbitrary pulse counts
        for (int k = 0; k < 16; k++) begin
            pulses = ($urandom_range(0, 1) == 1) ? NBITS : int'($urandom_range(0, NBITS + 2));
            pw = 8'($urandom);
            mw = 8'($urandom);
            run_frame(pulses, pw, mw, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
